// File: rtl/tow_pkg.sv
// Shared types and constants for the tug-of-war bot.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package tow_pkg;

  // Bot round state
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_WAIT  = 3'd2,
    ST_PRESS = 3'd3,
    ST_DONE  = 3'd4
  } bot_state_t;

  // LED bar codes the game uses to cue a round
  localparam logic [6:0] LED_READY = 7'h7F;
  localparam logic [6:0] LED_GO    = 7'h00;

  // Fibonacci taps for x^8+x^6+x^5+x^4+1 on a left-shifting register
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Delay and hold counters share one width
  localparam int CNT_W = 12;

  // One LFSR step: shift left, feedback enters at bit 0
  function automatic logic [7:0] lfsr_step(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAPS)};
  endfunction

  // The all-zero state is a lock-up state, so a zero seed is remapped
  function automatic logic [7:0] lfsr_seed(input logic [7:0] s);
    return (s == 8'h00) ? 8'h01 : s;
  endfunction

endpackage

// File: rtl/bot_lfsr.sv
// Free-running 8-bit maximal-length LFSR supplying the random reaction term.
// Latency: new value every clk edge; reset loads the (non-zero) seed.
// Backpressure: none, advances unconditionally.
module bot_lfsr
  import tow_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] value
);

  localparam logic [7:0] SEED_FIXED = lfsr_seed(SEED);

  // Advance every edge regardless of FSM state so delays decorrelate from play
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value <= SEED_FIXED;
    end else begin
      value <= lfsr_step(value);
    end
  end

endmodule

// File: rtl/tow_bot.sv
// Automated tug-of-war opponent: answers the GO cue with a timed button press.
// Latency: press rises D+2 edges after GO is first sampled, held HOLD cycles.
// Backpressure: none; led is level-sampled, en=0 forces IDLE on the next edge.
// Board use: press is ORed with the right push button into pbr, gated by en.
module tow_bot
  import tow_pkg::*;
#(
  parameter int         BASE_DELAY = 100,
  parameter int         RAND_BITS  = 6,
  parameter int         HOLD       = 10,
  parameter logic [7:0] SEED       = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [6:0] led,
  output logic       press,
  output logic       busy,
  output logic       missed
);

  // Selects the low RAND_BITS of the LFSR; zero width gives a fixed delay
  localparam logic [7:0]       RAND_MASK = 8'((1 << RAND_BITS) - 1);
  localparam logic [CNT_W-1:0] BASE_CNT  = CNT_W'(BASE_DELAY);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD - 1);

  bot_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [6:0]       led_q;
  logic             missed_d;
  logic [7:0]       lfsr_val;
  logic [CNT_W-1:0] delay;

  bot_lfsr #(
    .SEED (SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .value (lfsr_val)
  );

  // Reaction delay drawn from the LFSR value current at the ARMED->WAIT edge
  assign delay = BASE_CNT + {4'b0000, lfsr_val & RAND_MASK};

  // Register the LED bar once so the FSM works on a stable sample
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_q <= 7'h00;
    end else begin
      led_q <= led;
    end
  end

  // Next-state logic; disable overrides every state, and an abort in WAIT
  // takes priority over the delay expiring on the same edge
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hold_d   = hold_q;
    missed_d = 1'b0;
    if (!en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (led_q == LED_READY) begin
            state_d = ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (led_q == LED_GO) begin
            state_d = ST_WAIT;
            cnt_d   = delay;
          end else if (led_q != LED_READY) begin
            state_d = ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (led_q != LED_GO) begin
            state_d  = ST_IDLE;
            missed_d = 1'b1;
          end else if (cnt_q == '0) begin
            state_d = ST_PRESS;
            hold_d  = HOLD_LOAD;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_PRESS: begin
          if (hold_q == '0) begin
            state_d = ST_DONE;
          end else begin
            hold_d = hold_q - 1'b1;
          end
        end
        ST_DONE: begin
          if (led_q != LED_GO) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State, counters and registered outputs; outputs decode the next state so
  // they line up with the state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      press   <= 1'b0;
      busy    <= 1'b0;
      missed  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      press   <= (state_d == ST_PRESS);
      busy    <= (state_d != ST_IDLE);
      missed  <= missed_d;
    end
  end

endmodule

// File: tb/tb_tow_bot.sv
// Bench for tow_bot: three instances share stimulus, each scenario checks one.
// Latency: n/a.
// Backpressure: n/a.
module tb_tow_bot;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [6:0] led;

  logic press_a, busy_a, missed_a;
  logic press_b, busy_b, missed_b;
  logic press_r, busy_r, missed_r;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  logic [7:0] m_lfsr;

  always #5 clk = ~clk;

  tow_bot #(.BASE_DELAY(5), .RAND_BITS(0), .HOLD(3), .SEED(8'hA5)) u_a (
    .clk(clk), .rst(rst), .en(en), .led(led),
    .press(press_a), .busy(busy_a), .missed(missed_a));

  tow_bot #(.BASE_DELAY(20), .RAND_BITS(0), .HOLD(3), .SEED(8'h3C)) u_b (
    .clk(clk), .rst(rst), .en(en), .led(led),
    .press(press_b), .busy(busy_b), .missed(missed_b));

  tow_bot #(.BASE_DELAY(100), .RAND_BITS(6), .HOLD(10), .SEED(8'hA5)) u_r (
    .clk(clk), .rst(rst), .en(en), .led(led),
    .press(press_r), .busy(busy_r), .missed(missed_r));

  // Reference LFSR for u_r: x^8+x^6+x^5+x^4+1, left shift, seed A5
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) m_lfsr <= 8'hA5;
    else      m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic settle();
    en  = 1'b1;
    led = 7'h08;
    tick(16);
  endtask

  task automatic ready_go();
    led = 7'h7F;
    tick(4);
    led = 7'h00;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    en  = 1'b1;
    led = 7'h7F;
    tick(3);
    checks++;
    if ({press_a, busy_a, missed_a} !== 3'b000) begin
      errors++;
      $display("FAIL reset_a: got press/busy/missed=%b required 000", {press_a, busy_a, missed_a});
    end
    checks++;
    if ({press_r, busy_r, missed_r, press_b, busy_b, missed_b} !== 6'b0) begin
      errors++;
      $display("FAIL reset_rb: got %b required 000000",
               {press_r, busy_r, missed_r, press_b, busy_b, missed_b});
    end
    rst = 1'b1;
    tick(1);
    checks++;
    if (busy_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: got busy=%b required 0", busy_a);
    end
  endtask

  task automatic test_nominal();
    int n;
    int h;
    int d;
    settle();
    ready_go();
    tick(1);
    exp_q.push_back(5);
    n = 1;
    while (press_a !== 1'b1 && n < 40) begin
      tick(1);
      n++;
    end
    d = exp_q.pop_front();
    checks++;
    if (n !== d + 3) begin
      errors++;
      $display("FAIL nominal_rise: got press after %0d samples required %0d", n, d + 3);
    end
    h = 0;
    while (press_a === 1'b1 && h < 40) begin
      h++;
      tick(1);
    end
    checks++;
    if (h !== 3) begin
      errors++;
      $display("FAIL nominal_hold: got %0d cycles required 3", h);
    end
    tick(5);
    checks++;
    if ({press_a, busy_a} !== 2'b01) begin
      errors++;
      $display("FAIL nominal_done: got press/busy=%b required 01", {press_a, busy_a});
    end
    led = 7'h08;
    tick(1);
    checks++;
    if (busy_a !== 1'b1) begin
      errors++;
      $display("FAIL nominal_busy_hold: got busy=%b required 1", busy_a);
    end
    tick(1);
    checks++;
    if (busy_a !== 1'b0) begin
      errors++;
      $display("FAIL nominal_busy_fall: got busy=%b required 0", busy_a);
    end
  endtask

  task automatic test_opponent_wins();
    int mcount;
    int mfirst;
    int pseen;
    settle();
    ready_go();
    tick(8);
    led = 7'h10;
    mcount = 0;
    mfirst = -1;
    pseen  = 0;
    for (int i = 1; i <= 6; i++) begin
      tick(1);
      if (missed_b === 1'b1) begin
        mcount++;
        if (mfirst < 0) mfirst = i;
      end
      if (press_b === 1'b1) pseen++;
    end
    checks++;
    if (mcount !== 1 || mfirst !== 2) begin
      errors++;
      $display("FAIL opponent_missed: got %0d pulses first at %0d required 1 at 2", mcount, mfirst);
    end
    checks++;
    if (pseen !== 0 || busy_b !== 1'b0) begin
      errors++;
      $display("FAIL opponent_idle: got press cycles %0d busy=%b required 0 and 0", pseen, busy_b);
    end
  endtask

  task automatic test_simultaneous();
    int pseen;
    settle();
    ready_go();
    tick(6);
    led = 7'h08;
    tick(1);
    checks++;
    if ({press_a, missed_a} !== 2'b00) begin
      errors++;
      $display("FAIL simul_before: got press/missed=%b required 00", {press_a, missed_a});
    end
    tick(1);
    checks++;
    if ({press_a, missed_a} !== 2'b01) begin
      errors++;
      $display("FAIL simul_abort: got press/missed=%b required 01", {press_a, missed_a});
    end
    pseen = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (press_a === 1'b1 || missed_a === 1'b1) pseen++;
    end
    checks++;
    if (pseen !== 0) begin
      errors++;
      $display("FAIL simul_after: got %0d press/missed cycles required 0", pseen);
    end
  endtask

  task automatic test_glitch();
    int bad;
    settle();
    led = 7'h7F;
    tick(4);
    led = 7'h08;
    tick(2);
    led = 7'h00;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (press_a === 1'b1 || busy_a === 1'b1) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL glitch_no_arm: got %0d active cycles required 0", bad);
    end
  endtask

  task automatic test_disable();
    int n;
    int pseen;
    settle();
    ready_go();
    n = 0;
    while (press_a !== 1'b1 && n < 40) begin
      tick(1);
      n++;
    end
    checks++;
    if (press_a !== 1'b1) begin
      errors++;
      $display("FAIL disable_reach_press: got press=%b required 1", press_a);
    end
    en = 1'b0;
    tick(1);
    checks++;
    if ({press_a, busy_a} !== 2'b00) begin
      errors++;
      $display("FAIL disable_drop: got press/busy=%b required 00", {press_a, busy_a});
    end
    en = 1'b1;
    pseen = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (press_a === 1'b1 || busy_a === 1'b1) pseen++;
    end
    checks++;
    if (pseen !== 0) begin
      errors++;
      $display("FAIL disable_reenable: got %0d active cycles required 0", pseen);
    end
  endtask

  task automatic test_async_reset();
    int n;
    settle();
    ready_go();
    n = 0;
    while (press_a !== 1'b1 && n < 40) begin
      tick(1);
      n++;
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (press_a !== 1'b0 || n >= 40) begin
      errors++;
      $display("FAIL async_reset: got press=%b (wait %0d) required 0", press_a, n);
    end
    tick(1);
    rst = 1'b1;
    tick(1);
  endtask

  task automatic test_random();
    int seen[int];
    int n;
    int d;
    int e;
    int h;
    int zeros;
    int lfsr_bad;
    zeros    = 0;
    lfsr_bad = 0;
    for (int r = 0; r < 16; r++) begin
      settle();
      tick(r);
      ready_go();
      tick(1);
      exp_q.push_back(100 + int'(m_lfsr & 8'h3F));
      if (u_r.lfsr_val !== m_lfsr) lfsr_bad++;
      n = 1;
      while (press_r !== 1'b1 && n < 300) begin
        tick(1);
        n++;
        if (u_r.lfsr_val === 8'h00) zeros++;
      end
      d = n - 3;
      e = exp_q.pop_front();
      checks++;
      if (d !== e || d < 100 || d > 163) begin
        errors++;
        $display("FAIL random_delay round %0d: got %0d required %0d (range 100..163)", r, d, e);
      end
      seen[d] = 1;
      h = 0;
      while (press_r === 1'b1 && h < 40) begin
        h++;
        tick(1);
      end
      checks++;
      if (h !== 10) begin
        errors++;
        $display("FAIL random_hold round %0d: got %0d cycles required 10", r, h);
      end
    end
    checks++;
    if (seen.num() < 4) begin
      errors++;
      $display("FAIL random_distinct: got %0d distinct delays required at least 4", seen.num());
    end
    checks++;
    if (zeros !== 0 || lfsr_bad !== 0) begin
      errors++;
      $display("FAIL random_lfsr: got %0d zero reads %0d sequence errors required 0 and 0",
               zeros, lfsr_bad);
    end
  endtask

  initial begin
    rst = 1'b0;
    en  = 1'b0;
    led = 7'h00;
    test_reset();
    test_nominal();
    test_opponent_wins();
    test_simultaneous();
    test_glitch();
    test_disable();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
